voice_mix_sequencer: RTL and testbench
======================================

# voice_mix_sequencer

Upstream/downstream companion to the `multiplier` block. Once per audio sample tick it scales each voice sample by its gain, one voice at a time, by driving a single shared `multiplier` through its trigger/ready/done handshake. It sums the products in a widened signed accumulator and emits one saturated mixed sample with a valid pulse. It sits between the voice generators / envelope stage and the output DAC path.

## Interface
Parameters:
- `C_WIDTH`, 16: sample, gain and product width (signed two's complement). Must match the connected multiplier.
- `NUM_VOICES`, 4: voices mixed per tick (≥1).
- `TIMEOUT`, 64: maximum cycles spent waiting for `mul_done` before aborting.

Ports (one clock; reset is synchronous and active-high):
- `ctl_clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: sample tick. Accepted only in IDLE.
- `voice_sample` in `NUM_VOICES*C_WIDTH`: voice k at bits `[k*C_WIDTH +: C_WIDTH]`.
- `voice_gain` in `NUM_VOICES*C_WIDTH`: gains, same packing.
- `busy` out 1: high from the cycle after `start` is accepted until the mix completes.
- `mix_out` out `C_WIDTH`: saturated mix. Held until the next mix.
- `mix_valid` out 1: one-cycle pulse when `mix_out` updates.
- `overflow` out 1: valid with `mix_valid`. 1 if saturation occurred.
- `err` out 1: one-cycle pulse on timeout abort.
- `mul_a`, `mul_b` out `C_WIDTH`: multiplier operands.
- `mul_trigger` out 1: multiplier start.
- `mul_ready` in 1, `mul_done` in 1, `mul_y` in `C_WIDTH`: multiplier status and result.

## Operation
- **States:** IDLE, ISSUE, WAIT, OUTPUT.
- **IDLE:**
  - `start`=1 latches all of `voice_sample`/`voice_gain`.
  - Clears the accumulator and sets voice index 0.
  - Transitions to ISSUE.
- **ISSUE:**
  - `mul_a`/`mul_b` are driven from the latched sample/gain of the current voice.
  - `mul_trigger = (state==ISSUE) && mul_ready`, so it is high for exactly one cycle per voice.
  - That cycle moves the FSM to WAIT. While `mul_ready`=0 the FSM stays in ISSUE with the trigger low.
- **WAIT:**
  - The first cycle with `mul_done`=1 adds sign-extended `mul_y` into the accumulator.
  - The FSM then goes to ISSUE for the next voice, or to OUTPUT after voice `NUM_VOICES-1`.
  - `mul_done` is ignored in every state except WAIT.
- **OUTPUT:**
  - Registers the saturated accumulator to `mix_out`, pulses `mix_valid`, and sets `overflow`.
  - Returns to IDLE.
- **Accumulator:** signed, `C_WIDTH + clog2(NUM_VOICES) + 1` bits, so it never wraps.
- **Saturation:** clamp to [-2^(C_WIDTH-1), 2^(C_WIDTH-1)-1]. `overflow`=1 iff clamped.
- **Timeout:**
  - A WAIT-cycle counter resets on WAIT entry.
  - When it reaches `TIMEOUT` without `mul_done`, pulse `err`, go to IDLE, and leave `mix_out` unchanged with no `mix_valid`.
- `start` while not in IDLE is ignored (not queued).
- `mul_a`/`mul_b` hold stable from ISSUE entry through the end of WAIT.

## Timing
- **Reset values:** `busy`, `mix_out`, `mix_valid`, `overflow`, `err`, `mul_a`, `mul_b`, `mul_trigger` all 0. FSM in IDLE.
- **Reset mid-operation:** next cycle is IDLE with all of the above reset values. A late `mul_done` is ignored. The connected multiplier shares `reset`.
- **Per-voice latency:** with `mul_ready`=1 and `mul_done` asserted L cycles after the trigger cycle:
  - `start` is sampled at cycle 0.
  - Voice k is triggered at cycle 1+k(L+1).
  - `mix_valid` is high at cycle N(L+1)+1, where N=`NUM_VOICES`.
  - `busy` is high for cycles 1..N(L+1)+1.
  - `start` is accepted again at cycle N(L+1)+2.
- **Backpressure:** each cycle `mul_ready`=0 in ISSUE adds one cycle of latency and does not change the result.
- **Result sampling:** `mul_y` is sampled only in the cycle `mul_done`=1 within WAIT.

## Test plan
All scenarios use `C_WIDTH`=16, `NUM_VOICES`=4, and a behavioural multiplier (low 16 bits of the signed product) with L=3 and `mul_ready`=1 unless stated.

1. **Basic mix:** samples {3,-2,100,0}, gains {2,2,1,5}, pulse `start` → `mix_out`=102, `overflow`=0, `mix_valid` exactly at cycle 17, exactly 4 `mul_trigger` pulses.
2. **Saturation:**
   - Samples all 16000, gains all 2 → `mix_out`=32767, `overflow`=1.
   - Samples all -16000, gains all 2 → `mix_out`=-32768, `overflow`=1.
3. **Backpressure:** hold `mul_ready`=0 for 5 cycles during voice 2's ISSUE (vectors from scenario 1) → no trigger while low, `mix_out`=102, `mix_valid` at cycle 22.
4. **Start while busy:** pulse `start` again at cycle 6 → ignored. Exactly one `mix_valid`, exactly 4 triggers.
5. **Reset mid-operation:** assert `reset` at cycle 8 for 1 cycle → all outputs 0 on the next cycle, no `mix_valid`. A fresh `start` then gives 102 with the standard latency.
6. **Timeout:** multiplier never asserts `mul_done` → `err` pulses 64 cycles after WAIT entry, FSM in IDLE, `mix_out` unchanged, no `mix_valid`.

Source files
------------

// File: rtl/voice_mix_sequencer.sv
// voice_mix_sequencer
//   Once per sample tick, scales each voice sample by its gain through a single
//   shared multiplier (trigger/ready/done handshake), accumulates the products
//   in a widened signed accumulator and emits one saturated mixed sample.
//
// Ports
//   ctl_clk, reset        clock, synchronous active-high reset
//   start                 sample tick, accepted only when idle
//   voice_sample/gain     NUM_VOICES packed signed words, voice k at [k*C_WIDTH +: C_WIDTH]
//   busy                  high from the cycle after start is accepted until the mix completes
//   mix_out/mix_valid     saturated mix and its one-cycle valid pulse
//   overflow              set with mix_valid when the mix was clamped
//   err                   one-cycle pulse when the multiplier fails to answer in time
//   mul_a/mul_b/mul_trigger   multiplier operands and start
//   mul_ready/mul_done/mul_y  multiplier status and result
module voice_mix_sequencer #(
  parameter int C_WIDTH    = 16,
  parameter int NUM_VOICES = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                          ctl_clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_VOICES*C_WIDTH-1:0] voice_sample,
  input  logic [NUM_VOICES*C_WIDTH-1:0] voice_gain,
  output logic                          busy,
  output logic [C_WIDTH-1:0]            mix_out,
  output logic                          mix_valid,
  output logic                          overflow,
  output logic                          err,
  output logic [C_WIDTH-1:0]            mul_a,
  output logic [C_WIDTH-1:0]            mul_b,
  output logic                          mul_trigger,
  input  logic                          mul_ready,
  input  logic                          mul_done,
  input  logic [C_WIDTH-1:0]            mul_y
);

  // One guard bit beyond log2(voices) so the running sum can never wrap.
  localparam int AW = C_WIDTH + $clog2(NUM_VOICES) + 1;
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [VW-1:0] LAST_V = VW'(NUM_VOICES - 1);
  localparam logic [TW-1:0] LAST_W = TW'(TIMEOUT - 1);
  localparam logic signed [AW-1:0] SMAX = {{(AW-C_WIDTH+1){1'b0}}, {(C_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_t;

  state_t                    state;
  logic [VW-1:0]             vidx;
  logic [VW-1:0]             vnext;
  logic [TW-1:0]             wcnt;
  logic signed [C_WIDTH-1:0] smp  [NUM_VOICES];
  logic signed [C_WIDTH-1:0] gain [NUM_VOICES];
  logic signed [AW-1:0]      acc;
  logic signed [AW-1:0]      mul_y_x;
  logic signed [AW-1:0]      acc_sum;
  logic [C_WIDTH:0]          sat_res;

  // Returns {clamped, value}: value limited to the C_WIDTH signed range.
  function automatic logic [C_WIDTH:0] saturate(input logic signed [AW-1:0] v);
    if (v > SMAX)
      return {1'b1, 1'b0, {(C_WIDTH-1){1'b1}}};
    else if (v < SMIN)
      return {1'b1, 1'b1, {(C_WIDTH-1){1'b0}}};
    else
      return {1'b0, v[C_WIDTH-1:0]};
  endfunction

  assign mul_y_x     = {{(AW-C_WIDTH){mul_y[C_WIDTH-1]}}, mul_y};
  assign acc_sum     = acc + mul_y_x;
  assign sat_res     = saturate(acc_sum);
  assign vnext       = vidx + VW'(1);
  assign mul_trigger = (state == ISSUE) && mul_ready;

  always_ff @(posedge ctl_clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      overflow  <= 1'b0;
      err       <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      vidx      <= '0;
      wcnt      <= '0;
    end else begin
      mix_valid <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < NUM_VOICES; k++) begin
              smp[k]  <= voice_sample[k*C_WIDTH +: C_WIDTH];
              gain[k] <= voice_gain[k*C_WIDTH +: C_WIDTH];
            end
            // Operands for voice 0 come straight from the inputs so they are
            // stable on the very first ISSUE cycle.
            mul_a <= voice_sample[C_WIDTH-1:0];
            mul_b <= voice_gain[C_WIDTH-1:0];
            acc   <= '0;
            vidx  <= '0;
            busy  <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (mul_ready) begin
            wcnt  <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mul_done) begin
            acc <= acc_sum;
            if (vidx == LAST_V) begin
              // Result is registered on the way into OUTPUT so mix_valid is
              // visible during the OUTPUT cycle itself.
              mix_out   <= sat_res[C_WIDTH-1:0];
              overflow  <= sat_res[C_WIDTH];
              mix_valid <= 1'b1;
              state     <= OUTPUT;
            end else begin
              vidx  <= vnext;
              mul_a <= smp[vnext];
              mul_b <= gain[vnext];
              state <= ISSUE;
            end
          end else if (wcnt == LAST_W) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
        end
        OUTPUT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mix_sequencer.sv
// Bench for voice_mix_sequencer: behavioural multiplier (latency 3), a
// scoreboard queue of expected mixes pushed at stimulus time and popped on
// mix_valid, and directed scenarios in a single initial block.
module tb_voice_mix_sequencer;
  localparam int W = 16;
  localparam int N = 4;
  localparam int L = 3;

  logic           ctl_clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [N*W-1:0] voice_sample = '0;
  logic [N*W-1:0] voice_gain = '0;
  logic           busy;
  logic [W-1:0]   mix_out;
  logic           mix_valid;
  logic           overflow;
  logic           err;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic           mul_trigger;
  logic           mul_ready = 1'b1;
  logic           mul_done = 1'b0;
  logic [W-1:0]   mul_y = '0;

  typedef struct {
    logic [W-1:0] mix;
    logic         ovf;
    int           k;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   nchecks = 0;
  int   nerrors = 0;
  int   cyc = 0;
  int   tstart = 0;
  int   trig_cnt = 0;
  int   mv_cnt = 0;
  int   err_cnt = 0;
  int   err_k = -1;
  logic err_busy = 1'b1;
  bit   done_en = 1'b1;
  int   mcnt = 0;

  voice_mix_sequencer #(.C_WIDTH(W), .NUM_VOICES(N), .TIMEOUT(64)) dut (
    .ctl_clk(ctl_clk), .reset(reset), .start(start),
    .voice_sample(voice_sample), .voice_gain(voice_gain),
    .busy(busy), .mix_out(mix_out), .mix_valid(mix_valid),
    .overflow(overflow), .err(err),
    .mul_a(mul_a), .mul_b(mul_b), .mul_trigger(mul_trigger),
    .mul_ready(mul_ready), .mul_done(mul_done), .mul_y(mul_y)
  );

  always #5 ctl_clk = ~ctl_clk;
  always @(posedge ctl_clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] mul_lo(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[W-1:0];
  endfunction

  function automatic exp_t model(input logic [N*W-1:0] s, input logic [N*W-1:0] g, input int k);
    int           sum;
    logic [W-1:0] y;
    exp_t         e;
    sum = 0;
    for (int v = 0; v < N; v++) begin
      y = mul_lo(s[v*W +: W], g[v*W +: W]);
      sum += int'($signed(y));
    end
    if (sum > 32767) begin
      e.mix = 16'h7fff; e.ovf = 1'b1;
    end else if (sum < -32768) begin
      e.mix = 16'h8000; e.ovf = 1'b1;
    end else begin
      e.mix = sum[W-1:0]; e.ovf = 1'b0;
    end
    e.k = k;
    return e;
  endfunction

  function automatic logic [N*W-1:0] pack4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchecks++;
    assert (obs === expv) else begin
      nerrors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Behavioural multiplier: result captured on trigger, done asserted so the
  // sequencer sees it L cycles after the trigger cycle.
  always @(posedge ctl_clk) begin
    mul_done <= 1'b0;
    if (reset) begin
      mcnt <= 0;
    end else if (mul_trigger) begin
      mcnt  <= L;
      mul_y <= mul_lo(mul_a, mul_b);
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 2 && done_en) mul_done <= 1'b1;
    end
  end

  // Monitor on the falling edge: count events, pop scoreboard on mix_valid.
  always @(negedge ctl_clk) begin
    if (mul_trigger) trig_cnt++;
    if (!mul_ready) chk("trig_while_not_ready", 32'(mul_trigger), 32'd0);
    if (err) begin
      err_cnt++;
      err_k    = cyc - tstart;
      err_busy = busy;
    end
    if (mix_valid) begin
      mv_cnt++;
      nchecks++;
      assert (sb.size() != 0) else begin
        nerrors++;
        $error("FAIL unexpected_mix_valid: observed mix_out %0d expected no output", mix_out);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("mix_out", 32'(mix_out), 32'(mon_e.mix));
        chk("overflow", 32'(overflow), 32'(mon_e.ovf));
        chk("mix_valid_cycle", 32'(cyc - tstart), 32'(mon_e.k));
      end
    end
  end

  task automatic tick();
    @(posedge ctl_clk);
    #1;
  endtask

  task automatic tick_to(input int k);
    int g;
    g = 0;
    while ((cyc - tstart) < k && g < 2000) begin
      tick();
      g++;
    end
  endtask

  task automatic pulse_start();
    start  = 1'b1;
    tstart = cyc;
    tick();
    start  = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_mix_out"}, 32'(mix_out), 32'd0);
    chk({tag, "_mix_valid"}, 32'(mix_valid), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_mul_a"}, 32'(mul_a), 32'd0);
    chk({tag, "_mul_b"}, 32'(mul_b), 32'd0);
    chk({tag, "_mul_trigger"}, 32'(mul_trigger), 32'd0);
  endtask

  logic [N*W-1:0] s_basic, g_basic;
  int t0, m0, e0;

  initial begin
    s_basic = pack4(3, -2, 100, 0);
    g_basic = pack4(2, 2, 1, 5);

    // Reset state
    repeat (3) tick();
    check_zero("reset");
    reset = 1'b0;
    tick();

    // Basic mix
    voice_sample = s_basic; voice_gain = g_basic;
    t0 = trig_cnt; m0 = mv_cnt;
    sb.push_back(model(s_basic, g_basic, 17));
    pulse_start();
    chk("basic_busy_c1", 32'(busy), 32'd1);
    chk("basic_mul_a_c1", 32'(mul_a), 32'd3);
    tick_to(17);
    chk("basic_valid_c17", 32'(mix_valid), 32'd1);
    chk("basic_busy_c17", 32'(busy), 32'd1);
    tick_to(18);
    chk("basic_busy_c18", 32'(busy), 32'd0);
    chk("basic_valid_c18", 32'(mix_valid), 32'd0);
    chk("basic_triggers", 32'(trig_cnt - t0), 32'd4);
    chk("basic_valids", 32'(mv_cnt - m0), 32'd1);

    // Saturation high and low
    voice_sample = pack4(16000, 16000, 16000, 16000); voice_gain = pack4(2, 2, 2, 2);
    m0 = mv_cnt;
    sb.push_back(model(voice_sample, voice_gain, 17));
    pulse_start();
    tick_to(19);
    voice_sample = pack4(-16000, -16000, -16000, -16000);
    sb.push_back(model(voice_sample, voice_gain, 17));
    pulse_start();
    tick_to(19);
    chk("sat_valids", 32'(mv_cnt - m0), 32'd2);
    chk("sat_low_mix", 32'(mix_out), 32'h8000);

    // Backpressure on voice 2
    voice_sample = s_basic; voice_gain = g_basic;
    t0 = trig_cnt; m0 = mv_cnt;
    sb.push_back(model(s_basic, g_basic, 22));
    pulse_start();
    tick_to(9);
    mul_ready = 1'b0;
    tick_to(14);
    mul_ready = 1'b1;
    tick_to(23);
    chk("bp_triggers", 32'(trig_cnt - t0), 32'd4);
    chk("bp_valids", 32'(mv_cnt - m0), 32'd1);

    // Start while busy is ignored
    t0 = trig_cnt; m0 = mv_cnt;
    sb.push_back(model(s_basic, g_basic, 17));
    pulse_start();
    tick_to(6);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick_to(18);
    chk("busy_start_idle_c18", 32'(busy), 32'd0);
    tick_to(30);
    chk("busy_start_triggers", 32'(trig_cnt - t0), 32'd4);
    chk("busy_start_valids", 32'(mv_cnt - m0), 32'd1);

    // Reset mid-operation
    m0 = mv_cnt;
    pulse_start();
    tick_to(8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("midreset");
    repeat (30) tick();
    chk("midreset_no_valid", 32'(mv_cnt - m0), 32'd0);
    sb.push_back(model(s_basic, g_basic, 17));
    pulse_start();
    tick_to(19);
    chk("midreset_restart_valids", 32'(mv_cnt - m0), 32'd1);
    chk("midreset_restart_mix", 32'(mix_out), 32'd102);

    // Timeout: multiplier never answers
    done_en = 1'b0;
    t0 = trig_cnt; m0 = mv_cnt; e0 = err_cnt;
    pulse_start();
    for (int i = 0; i < 200 && err_cnt == e0; i++) tick();
    chk("timeout_err_seen", 32'(err_cnt - e0), 32'd1);
    chk("timeout_err_cycle", 32'(err_k), 32'd66);
    chk("timeout_idle_busy", 32'(err_busy), 32'd0);
    repeat (5) tick();
    chk("timeout_err_pulse", 32'(err_cnt - e0), 32'd1);
    chk("timeout_mix_held", 32'(mix_out), 32'd102);
    chk("timeout_no_valid", 32'(mv_cnt - m0), 32'd0);
    chk("timeout_triggers", 32'(trig_cnt - t0), 32'd1);
    done_en = 1'b1;

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
